// File: rtl/gb_alu_seq.sv
// Handshaked Game Boy ALU: single-pass 8-bit ops with Z/N/H/C flags and a
// two-pass 16-bit ADD (low byte, then high byte plus stored carry).
module gb_alu_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   opcode,
    input  logic [2*DATA_WIDTH-1:0]   operand_A,
    input  logic [2*DATA_WIDTH-1:0]   operand_B,
    input  logic [3:0]                flags_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   result,
    output logic [3:0]                flags_out
);
    localparam int W = DATA_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADC   = 'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SBC   = 'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = 'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_CP    = 'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_INC   = 'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_DEC   = 'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD16 = 'hA;

    typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, DONE} state_t;

    state_t           state, state_nxt;
    logic             alive;
    logic             accept;
    logic [2*W-1:0]   a_q, b_q;
    logic             z_q, carry_q;
    logic [2*W-1:0]   result_q;
    logic [3:0]       flags_q;

    logic [W-1:0]     a_n, b_n, nar_res;
    logic [3:0]       nar_flags;
    logic             use_c;
    logic [W:0]       wide;
    logic [4:0]       nib;
    logic [W:0]       lo_sum, hi_sum;
    logic [4:0]       hi_nib;

    assign accept = in_valid & in_ready;

    // alive keeps in_ready low until the first edge after reset release.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (opcode == OP_ADD16) ? EXEC_LO : DONE;
            EXEC_LO: state_nxt = EXEC_HI;
            EXEC_HI: state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = alive && (state == IDLE);
        out_valid = (state == DONE);
    end

    // Single-pass datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        a_n       = operand_A[W-1:0];
        b_n       = operand_B[W-1:0];
        use_c     = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? flags_in[0] : 1'b0;
        wide      = '0;
        nib       = '0;
        nar_res   = a_n;
        nar_flags = flags_in;
        case (opcode)
            OP_ADD, OP_ADC: begin
                wide      = {1'b0, a_n} + {1'b0, b_n} + {{W{1'b0}}, use_c};
                nib       = {1'b0, a_n[3:0]} + {1'b0, b_n[3:0]} + {4'b0, use_c};
                nar_res   = wide[W-1:0];
                nar_flags = {nar_res == '0, 1'b0, nib[4], wide[W]};
            end
            OP_SUB, OP_SBC, OP_CP: begin
                wide      = {1'b0, a_n} - {1'b0, b_n} - {{W{1'b0}}, use_c};
                nib       = {1'b0, a_n[3:0]} - {1'b0, b_n[3:0]} - {4'b0, use_c};
                nar_res   = (opcode == OP_CP) ? a_n : wide[W-1:0];
                nar_flags = {wide[W-1:0] == '0, 1'b1, nib[4], wide[W]};
            end
            OP_AND: begin
                nar_res   = a_n & b_n;
                nar_flags = {nar_res == '0, 1'b0, 1'b1, 1'b0};
            end
            OP_XOR: begin
                nar_res   = a_n ^ b_n;
                nar_flags = {nar_res == '0, 1'b0, 1'b0, 1'b0};
            end
            OP_OR: begin
                nar_res   = a_n | b_n;
                nar_flags = {nar_res == '0, 1'b0, 1'b0, 1'b0};
            end
            OP_INC: begin
                wide      = {1'b0, a_n} + (W+1)'(1);
                nib       = {1'b0, a_n[3:0]} + 5'd1;
                nar_res   = wide[W-1:0];
                nar_flags = {nar_res == '0, 1'b0, nib[4], flags_in[0]};
            end
            OP_DEC: begin
                wide      = {1'b0, a_n} - (W+1)'(1);
                nib       = {1'b0, a_n[3:0]} - 5'd1;
                nar_res   = wide[W-1:0];
                nar_flags = {nar_res == '0, 1'b1, nib[4], flags_in[0]};
            end
            default: begin
                nar_res   = a_n;
                nar_flags = flags_in;
            end
        endcase
    end

    // Two-pass 16-bit add works only on the captured operands.
    assign lo_sum = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]};
    assign hi_sum = {1'b0, a_q[2*W-1:W]} + {1'b0, b_q[2*W-1:W]} + {{W{1'b0}}, carry_q};
    assign hi_nib = {1'b0, a_q[W+3:W]} + {1'b0, b_q[W+3:W]} + {4'b0, carry_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q <= operand_A;
                    b_q <= operand_B;
                    z_q <= flags_in[3];
                    if (opcode != OP_ADD16) begin
                        result_q <= {{W{1'b0}}, nar_res};
                        flags_q  <= nar_flags;
                    end
                end
                EXEC_LO: begin
                    result_q <= {{W{1'b0}}, lo_sum[W-1:0]};
                    carry_q  <= lo_sum[W];
                end
                EXEC_HI: begin
                    result_q[2*W-1:W] <= hi_sum[W-1:0];
                    flags_q           <= {z_q, 1'b0, hi_nib[4], hi_sum[W]};
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_gb_alu_seq.sv
// Self-checking bench for gb_alu_seq: directed vectors, backpressure,
// mid-operation reset and random ops against an arithmetic reference model.
module tb_gb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] operand_A;
    logic [15:0] operand_B;
    logic [3:0]  flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  flags_out;

    int n_checks = 0;
    int n_pass   = 0;

    gb_alu_seq #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags_out (flags_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Returns {Z,N,H,C, result[15:0]} computed with plain integer arithmetic.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] f);
        int x, y, c, r, res;
        logic z, n, h, cy;
        x = int'(a[7:0]);
        y = int'(b[7:0]);
        c = (op == 4'h1 || op == 4'h3) ? int'(f[0]) : 0;
        z = 1'b0; n = 1'b0; h = 1'b0; cy = 1'b0; res = 0; r = 0;
        case (op)
            4'h0, 4'h1: begin
                r = x + y + c; res = r % 256;
                h = ((x % 16) + (y % 16) + c) > 15; cy = r > 255; z = (res == 0);
            end
            4'h2, 4'h3, 4'h7: begin
                r = x - y - c;
                res = (op == 4'h7) ? x : (r + 256) % 256;
                h = ((x % 16) - (y % 16) - c) < 0; cy = r < 0; n = 1'b1;
                z = ((r + 256) % 256) == 0;
            end
            4'h4: begin res = x & y; h = 1'b1; z = (res == 0); end
            4'h5: begin res = x ^ y; z = (res == 0); end
            4'h6: begin res = x | y; z = (res == 0); end
            4'h8: begin
                res = (x + 1) % 256; h = (x % 16) == 15; cy = f[0]; z = (res == 0);
            end
            4'h9: begin
                res = (x + 255) % 256; h = (x % 16) == 0; cy = f[0]; n = 1'b1; z = (res == 0);
            end
            4'hA: begin
                r = int'(a) + int'(b); res = r % 65536;
                h = ((int'(a) % 4096) + (int'(b) % 4096)) > 4095; cy = r > 65535; z = f[3];
            end
            default: return {f, 8'h00, a[7:0]};
        endcase
        return {z, n, h, cy, 16'(res)};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f);
        in_valid  = 1'b1;
        opcode    = op;
        operand_A = a;
        operand_B = b;
        flags_in  = f;
    endtask

    // Drops the request and scrambles the inputs to prove they were captured.
    task automatic scramble();
        in_valid  = 1'b0;
        opcode    = 4'($urandom_range(0, 15));
        operand_A = 16'($urandom);
        operand_B = 16'($urandom);
        flags_in  = 4'($urandom_range(0, 15));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input string tag);
        logic [19:0] e;
        int lat;
        e = model(op, a, b, f);
        @(negedge clk);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        drive(op, a, b, f);
        @(negedge clk);
        scramble();
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), (op == 4'hA) ? 32'd3 : 32'd1);
        check({tag, " result"}, 32'(result), 32'(e[15:0]));
        check({tag, " flags"}, 32'(flags_out), 32'(e[19:16]));
    endtask

    initial begin
        logic [19:0] e1, e2;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        scramble();

        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'(flags_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release in_ready before edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("release in_ready after edge", 32'(in_ready), 32'd1);

        run_op(4'h0, 16'h003A, 16'h00C6, 4'h0, "add 3a+c6");
        run_op(4'h3, 16'h003B, 16'h002A, 4'h1, "sbc 3b-2a-1");
        run_op(4'h7, 16'h003C, 16'h0040, 4'h0, "cp 3c,40");
        run_op(4'hA, 16'h8A23, 16'h0605, 4'h8, "add16 8a23+0605");
        run_op(4'hA, 16'h8A23, 16'h8A23, 4'h0, "add16 8a23+8a23");
        run_op(4'h8, 16'h00FF, 16'h0000, 4'h1, "inc ff");
        run_op(4'h9, 16'h0010, 16'h0000, 4'h0, "dec 10");
        run_op(4'hE, 16'hA55A, 16'h1234, 4'h6, "reserved e");
        run_op(4'h1, 16'hFF0F, 16'hAB01, 4'h1, "adc 0f+01+1");
        run_op(4'h4, 16'h00F0, 16'h000F, 4'h0, "and zero");

        // Backpressure: hold the result for three cycles with a second request pending.
        e1 = model(4'h2, 16'h0050, 16'h0021, 4'h0);
        e2 = model(4'h6, 16'h0081, 16'h0018, 4'h0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'h2, 16'h0050, 16'h0021, 4'h0);
        @(negedge clk);
        scramble();
        check("bp first valid", 32'(out_valid), 32'd1);
        drive(4'h6, 16'h0081, 16'h0018, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold result", 32'(result), 32'(e1[15:0]));
            check("bp hold flags", 32'(flags_out), 32'(e1[19:16]));
            check("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp after handshake valid", 32'(out_valid), 32'd0);
        check("bp after handshake in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        scramble();
        check("bp second valid", 32'(out_valid), 32'd1);
        check("bp second result", 32'(result), 32'(e2[15:0]));
        check("bp second flags", 32'(flags_out), 32'(e2[19:16]));

        // Reset while the high pass of ADD16 is in flight.
        @(negedge clk);
        drive(4'hA, 16'hFFFF, 16'h0001, 4'hF);
        @(negedge clk);
        scramble();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        check("midrst flags", 32'(flags_out), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst in_ready", 32'(in_ready), 32'd1);
        check("post rst no stale", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post rst still idle", 32'(out_valid), 32'd0);
        run_op(4'hA, 16'h12F8, 16'h0E09, 4'h0, "post rst add16");

        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
